// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and default widths for the MEM/WB pipeline skid stage.
//   mem_wb_ctrl_t : control bundle {reg_wr, sel_wb[1:0]}
//   mem_wb_data_t : datapath bundle {alu_o, rd_data, PC4, rd}
//   DEF_CTRL_W    : default control bundle width (3)
//   DEF_DATA_W    : default datapath bundle width (101)
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef struct packed {
        logic       reg_wr;
        logic [1:0] sel_wb;
    } mem_wb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_o;
        logic [31:0] rd_data;
        logic [31:0] PC4;
        logic [4:0]  rd;
    } mem_wb_data_t;

    localparam int DEF_CTRL_W = $bits(mem_wb_ctrl_t);
    localparam int DEF_DATA_W = $bits(mem_wb_data_t);

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One pipeline entry: valid flag plus control and data registers.
//   clk, rst_n : clock, asynchronous active-low reset (clears everything)
//   i_load     : capture i_ctrl/i_data and set valid
//   i_clear    : drop the entry (valid and ctrl to 0, data kept); wins over load
//   i_ctrl     : control bundle to capture
//   i_data     : datapath bundle to capture
//   o_valid    : entry holds a beat
//   o_ctrl     : held control bundle (zero whenever o_valid is 0)
//   o_data     : held datapath bundle
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Valid and control: cleared on drop so a bubble can never carry reg_wr.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end
    end

    // Data only moves on capture; a dropped entry keeps its stale payload,
    // which is harmless because consumers qualify it with valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load && !i_clear) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule : pipe_slot

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Valid/ready pipeline register for the MEM/WB bundle with optional skid entry.
// SKID=1: two entries (main + skid), in_ready comes straight from a register.
// SKID=0: one entry, in_ready = out_ready || !main_valid.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : kill held beats and any beat presented this cycle
//   in_valid   : upstream beat present
//   in_ready   : stage can accept a beat
//   in_ctrl    : upstream control bundle
//   in_data    : upstream datapath bundle
//   out_valid  : downstream beat present (registered)
//   out_ready  : downstream accepts the beat
//   out_ctrl   : control bundle, zero while out_valid is 0 (registered)
//   out_data   : datapath bundle (registered)
//   occupancy  : number of held beats, 0..2
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_from_skid;
    logic              w_main_clear;
    logic [CTRL_W-1:0] w_main_src_ctrl;
    logic [DATA_W-1:0] w_main_src_data;

    // With a skid entry, in_ready depends only on the skid register, which
    // breaks the combinational out_ready -> in_ready path.
    assign w_in_ready = (SKID != 0) ? !w_skid_valid : (out_ready || !w_main_valid);

    // A beat presented during flush is handshaken but discarded.
    assign w_in_fire  = in_valid && w_in_ready && !flush;
    assign w_out_fire = w_main_valid && out_ready;

    // Main entry refill: the skid beat has priority (it is older); otherwise
    // the incoming beat goes straight to main when main is free or leaving.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        if (!flush) begin
            if (w_skid_valid && w_out_fire) begin
                w_main_load      = 1'b1;
                w_main_from_skid = 1'b1;
            end else if (w_in_fire && (!w_main_valid || w_out_fire)) begin
                w_main_load = 1'b1;
            end
        end
    end

    assign w_main_clear    = flush || (w_out_fire && !w_main_load);
    assign w_main_src_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_src_data = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_src_ctrl),
        .i_data  (w_main_src_data),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic w_skid_load;
            logic w_skid_clear;

            // Accepted while main is stuck: park the beat in skid. Accepting
            // implies skid is empty, so load and clear never coincide.
            assign w_skid_load  = w_in_fire && w_main_valid && !w_out_fire;
            assign w_skid_clear = flush || (w_skid_valid && w_out_fire);

            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid_ctrl  = '0;
            assign w_skid_data  = '0;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_main_valid;
    // Slot already zeroes ctrl when empty; the gate keeps the bubble rule local.
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign out_data  = w_main_data;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Drives a SKID=1 and a SKID=0 instance from the same upstream/downstream
// signals and compares each against a FIFO-queue reference of the stage.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int CW = DEF_CTRL_W;
    localparam int DW = DEF_DATA_W;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          o1_in_ready, o1_valid, o0_in_ready, o0_valid;
    logic [CW-1:0] o1_ctrl, o0_ctrl;
    logic [DW-1:0] o1_data, o0_data;
    logic [1:0]    o1_occ, o0_occ;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t q1[$];
    beat_t q0[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(o1_valid), .out_ready(out_ready),
        .out_ctrl(o1_ctrl), .out_data(o1_data), .occupancy(o1_occ)
    );

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(o0_valid), .out_ready(out_ready),
        .out_ctrl(o0_ctrl), .out_data(o0_data), .occupancy(o0_occ)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        mem_wb_data_t d;
        d.alu_o   = $urandom;
        d.rd_data = $urandom;
        d.PC4     = $urandom;
        d.rd      = 5'($urandom);
        return d;
    endfunction

    task automatic set_beat(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    // Compare both instances against their queues, then advance one edge.
    // Capacity is 2 with a skid entry, 1 without; flush empties the queue.
    task automatic step(output bit acc1);
        bit    rdy1, rdy0, in1, in0, out1, out0;
        beat_t b;
        beat_t f1, f0;
        @(negedge clk);
        rdy1 = (q1.size() < 2);
        rdy0 = out_ready || (q0.size() == 0);
        f1 = '0;
        f0 = '0;
        if (q1.size() != 0) f1 = q1[0];
        if (q0.size() != 0) f0 = q0[0];
        check("s1_out_valid", o1_valid, q1.size() != 0);
        check("s1_out_ctrl",  o1_ctrl,  f1.ctrl);
        if (q1.size() != 0) check("s1_out_data", o1_data, f1.data);
        check("s1_occupancy", o1_occ,   q1.size());
        check("s1_in_ready",  o1_in_ready, rdy1);
        check("s0_out_valid", o0_valid, q0.size() != 0);
        check("s0_out_ctrl",  o0_ctrl,  f0.ctrl);
        if (q0.size() != 0) check("s0_out_data", o0_data, f0.data);
        check("s0_occupancy", o0_occ,   q0.size());
        check("s0_in_ready",  o0_in_ready, rdy0);
        b    = '{ctrl: in_ctrl, data: in_data};
        in1  = in_valid && rdy1;
        in0  = in_valid && rdy0;
        out1 = out_ready && (q1.size() != 0);
        out0 = out_ready && (q0.size() != 0);
        @(posedge clk);
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out1) void'(q1.pop_front());
            if (in1)  q1.push_back(b);
            if (out0) void'(q0.pop_front());
            if (in0)  q0.push_back(b);
        end
        acc1 = in1;
        #1;
    endtask

    // Hold the presented beat until the SKID=1 instance takes it.
    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
        bit acc = 1'b0;
        set_beat(c, d);
        for (int i = 0; i < 20 && !acc; i++) step(acc);
        check("send_accepted", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_s1_out_valid", o1_valid, 1'b0);
        check("rst_s1_out_ctrl",  o1_ctrl,  '0);
        check("rst_s1_out_data",  o1_data,  '0);
        check("rst_s1_occupancy", o1_occ,   2'd0);
        check("rst_s1_in_ready",  o1_in_ready, 1'b1);
        check("rst_s0_out_valid", o0_valid, 1'b0);
        check("rst_s0_out_data",  o0_data,  '0);
        check("rst_s0_occupancy", o0_occ,   2'd0);
    endtask

    initial begin
        bit acc;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, 1-cycle latency
        out_ready = 1'b1;
        set_beat(3'b101, {{(DW-8){1'b0}}, 8'hAA});
        step(acc);
        in_valid = 1'b0;
        step(acc);
        step(acc);

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            set_beat(CW'($urandom), rand_data());
            step(acc);
        end
        in_valid = 1'b0;
        repeat (3) step(acc);

        // A,B,C with downstream stalled, then released
        out_ready = 1'b0;
        send(3'b001, rand_data());
        send(3'b010, rand_data());
        set_beat(3'b011, rand_data());
        step(acc);
        step(acc);
        out_ready = 1'b1;
        send(3'b011, in_data);
        repeat (3) step(acc);

        // Flush at full occupancy with a beat presented
        out_ready = 1'b0;
        send(3'b111, rand_data());
        send(3'b110, rand_data());
        flush = 1'b1;
        set_beat(3'b101, rand_data());
        step(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step(acc);

        // Flush coinciding with a downstream handshake
        out_ready = 1'b0;
        send(3'b100, rand_data());
        send(3'b101, rand_data());
        out_ready = 1'b1;
        flush     = 1'b1;
        step(acc);
        flush = 1'b0;
        repeat (3) step(acc);

        // out_ready toggling every cycle with random upstream traffic
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'(i);
            in_valid  = 1'($urandom);
            in_ctrl   = CW'($urandom);
            in_data   = rand_data();
            step(acc);
        end

        // Random traffic with occasional flush
        for (int i = 0; i < 200; i++) begin
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            in_ctrl   = CW'($urandom);
            in_data   = rand_data();
            flush     = ($urandom_range(15, 0) == 0);
            step(acc);
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream, between edges
        out_ready = 1'b0;
        send(3'b111, rand_data());
        send(3'b011, rand_data());
        rst_n = 1'b0;
        #1;
        check_reset_state();
        q1.delete();
        q0.delete();
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_beat(3'b101, rand_data());
        step(acc);
        in_valid = 1'b0;
        repeat (2) step(acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_skid_stage

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 3, giving the width of the control bundle (reg_wr + sel_wb[1:0]).
REQ-002 The block SHALL have parameter DATA_W, default 101, giving the width of the datapath bundle (alu_o 32 + rd_data 32 + PC4 32 + rd 5).
REQ-003 The block SHALL have parameter SKID, default 1, where 1 selects a two-entry skid stage and 0 selects a single-entry stage.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill all held and incoming beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream datapath bundle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  control bundle, gated.
- out_data  out  DATA_W  datapath bundle.
- occupancy  out  2  number of held beats (0..2).

Function
REQ-005 A beat SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready, both sampled at the rising edge of clk.
REQ-006 out_valid, out_ctrl and out_data SHALL be driven only from registers (main entry); latency in->out SHALL be exactly 1 cycle when the stage is empty.
REQ-007 out_ctrl SHALL be all-zero whenever out_valid is 0, so that a bubble never asserts reg_wr.
REQ-008 For SKID=1, in_ready SHALL equal NOT skid_valid, driven from a register with no combinational path from out_ready.
REQ-009 For SKID=0, in_ready SHALL equal out_ready || !main_valid.
REQ-010 When a beat is accepted while main is valid and out_ready=0, the beat SHALL be captured into the skid entry (SKID=1 only).
REQ-011 When main is dequeued and skid is valid, skid SHALL move into main in the same edge and skid SHALL become empty; no new beat is accepted in that cycle.
REQ-012 When main is dequeued, skid is empty and an input beat transfers in the same cycle, the input beat SHALL load main directly (full throughput, 1 beat/cycle).
REQ-013 Beat order SHALL be preserved, and no beat SHALL be duplicated or lost except by flush.
REQ-014 flush SHALL take priority over every other event: at the next edge main_valid=0, skid_valid=0 and control registers=0; an input beat presented in the flush cycle SHALL be dropped.
REQ-015 A downstream handshake in the flush cycle SHALL still count as consumed, and the flushed beat SHALL NOT reappear.
REQ-016 Data registers SHALL load only on capture; flush and dequeue SHALL NOT clear data registers.
REQ-017 occupancy SHALL equal main_valid + skid_valid and SHALL never exceed 1 when SKID=0.
REQ-018 out_valid && !out_ready SHALL hold out_ctrl and out_data stable until transfer or flush.

Reset
REQ-019 Asserting rst_n low SHALL immediately force main_valid=0, skid_valid=0, all control and data registers=0, in_ready=1, out_valid=0 and occupancy=0.
REQ-020 Beats in flight when reset is asserted mid-operation SHALL be discarded, and the first accepted beat after deassertion SHALL appear after 1 cycle.
REQ-021 Reset deassertion SHALL be synchronised externally; the block SHALL NOT add a synchroniser.

Structure
REQ-022 Package pipe_pkg SHALL hold the default CTRL_W and DATA_W constants and the packed structs mem_wb_ctrl_t {reg_wr, sel_wb[1:0]} and mem_wb_data_t {alu_o[31:0], rd_data[31:0], PC4[31:0], rd[4:0]}.
REQ-023 Each entry SHALL be an instance of sub-module pipe_slot, a valid+ctrl+data register with load, clear and async reset; the skid slot SHALL exist only under SKID=1 generate.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset then in_valid=1 with ctrl=3'b101, data=0x...AA; out_ready=1 -> out_valid=1 with ctrl 101 on the next cycle, occupancy=1.
- Stream of 8 beats with out_ready=1 throughout -> 8 consecutive outputs in order, no gaps, in_ready constantly 1.
- Beats A,B,C with out_ready held 0 -> A in main, B in skid, in_ready=0, C held upstream; out_ready=1 -> A,B,C emerge on consecutive cycles.
- flush while occupancy=2 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; neither the held beats nor the incoming beat appear later.
- rst_n pulsed low mid-stream between edges -> outputs zero immediately, without waiting for clk.
- SKID=0 build with out_ready toggling every cycle -> in_ready equals out_ready || !out_valid each cycle, order preserved, occupancy ≤ 1.
